// File: rtl/line_clear_fx_timer_if.sv
// Signal bundle between the clear-event source and the line-clear effect timer.
// The master side issues tick/hit/abort; the slave side (the timer) returns the effect state.
interface line_clear_fx_timer_if #(
    parameter int CNT_W  = 6,
    parameter int LINE_W = 3
);
    logic              tick;
    logic              hit;
    logic [LINE_W-1:0] line_count;
    logic              abort;
    logic              active;
    logic              flash;
    logic [LINE_W-1:0] level;
    logic [CNT_W-1:0]  remaining;
    logic              done;

    modport master (
        output tick, hit, line_count, abort,
        input  active, flash, level, remaining, done
    );

    modport slave (
        input  tick, hit, line_count, abort,
        output active, flash, level, remaining, done
    );
endinterface

// File: rtl/line_clear_fx_timer.sv
// Line-clear effect timer: loads a line-count dependent duration on a clear event,
// counts it down on the frame tick, blinks the cleared rows and pulses done on expiry.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | no effect; all outputs 0, tick ignored, waits for a valid hit
//   S_RUN  | effect running; counts remaining down on tick, flash blinking
module line_clear_fx_timer #(
    parameter int CNT_W       = 6,
    parameter int LINE_W      = 3,
    parameter int MAX_LINES   = 4,
    parameter int BASE_TICKS  = 3,
    parameter int STEP_TICKS  = 5,
    parameter int BLINK_TICKS = 2,
    parameter int MODE        = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    line_clear_fx_timer_if.slave  bus
);

    localparam int               SUM_W   = CNT_W + LINE_W;
    localparam int               BC_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BLINK_TICKS - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_rem;
    logic [LINE_W-1:0] r_level;
    logic              r_flash;
    logic [BC_W-1:0]   r_bcnt;
    logic              r_done;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_rem_nxt;
    logic [LINE_W-1:0] w_level_nxt;
    logic              w_flash_nxt;
    logic [BC_W-1:0]   w_bcnt_nxt;
    logic              w_done_nxt;

    logic              w_hit_ok;
    logic [SUM_W-1:0]  w_dur_raw;
    logic [CNT_W-1:0]  w_dur;
    logic [CNT_W:0]    w_acc;
    logic [CNT_W-1:0]  w_rem_acc;
    logic [CNT_W-1:0]  w_rem_max;
    logic [LINE_W-1:0] w_level_max;

    // Out-of-range line counts are dropped here so they never disturb a running effect.
    assign w_hit_ok = bus.hit && (bus.line_count != '0) &&
                      (bus.line_count <= LINE_W'(MAX_LINES));

    assign w_dur_raw = SUM_W'(BASE_TICKS) +
                       (SUM_W'(bus.line_count) - SUM_W'(1)) * SUM_W'(STEP_TICKS);
    assign w_dur     = (w_dur_raw > SUM_W'(CNT_MAX)) ? CNT_MAX : w_dur_raw[CNT_W-1:0];

    assign w_acc       = {1'b0, r_rem} + {1'b0, w_dur};
    assign w_rem_acc   = w_acc[CNT_W] ? CNT_MAX : w_acc[CNT_W-1:0];
    assign w_rem_max   = (w_dur > r_rem) ? w_dur : r_rem;
    assign w_level_max = (bus.line_count > r_level) ? bus.line_count : r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_level <= '0;
            r_flash <= 1'b0;
            r_bcnt  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_level <= w_level_nxt;
            r_flash <= w_flash_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_level_nxt = r_level;
        w_flash_nxt = r_flash;
        w_bcnt_nxt  = r_bcnt;
        w_done_nxt  = 1'b0;

        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_rem_nxt   = '0;
            w_level_nxt = '0;
            w_flash_nxt = 1'b0;
            w_bcnt_nxt  = '0;
        end else if (w_hit_ok) begin
            w_state_nxt = S_RUN;
            if (r_state == S_IDLE || MODE == 0) begin
                w_rem_nxt   = w_dur;
                w_level_nxt = bus.line_count;
                w_flash_nxt = 1'b1;
                w_bcnt_nxt  = '0;
            end else begin
                // Extend/accumulate keep the flash phase so the blink stays smooth.
                w_level_nxt = w_level_max;
                w_rem_nxt   = (MODE == 1) ? w_rem_max : w_rem_acc;
            end
        end else if (bus.tick && r_state == S_RUN) begin
            if (r_rem <= CNT_W'(1)) begin
                w_state_nxt = S_IDLE;
                w_rem_nxt   = '0;
                w_level_nxt = '0;
                w_flash_nxt = 1'b0;
                w_bcnt_nxt  = '0;
                w_done_nxt  = 1'b1;
            end else begin
                w_rem_nxt = r_rem - CNT_W'(1);
                if (r_bcnt == BC_LAST) begin
                    w_bcnt_nxt  = '0;
                    w_flash_nxt = ~r_flash;
                end else begin
                    w_bcnt_nxt = r_bcnt + BC_W'(1);
                end
            end
        end
    end

    assign bus.active    = (r_state == S_RUN);
    assign bus.flash     = r_flash;
    assign bus.level     = r_level;
    assign bus.remaining = r_rem;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_line_clear_fx_timer.sv
// Scoreboard bench: four timers (restart, extend, accumulate, accumulate with a 4-bit counter)
// share one stimulus stream; a reference model predicts each output snapshot.
module tb_line_clear_fx_timer;

    logic       clk;
    logic       rst_n;
    logic       tick, hit, abort;
    logic [2:0] lc;

    line_clear_fx_timer_if #(.CNT_W(6), .LINE_W(3)) if0 ();
    line_clear_fx_timer_if #(.CNT_W(6), .LINE_W(3)) if1 ();
    line_clear_fx_timer_if #(.CNT_W(6), .LINE_W(3)) if2 ();
    line_clear_fx_timer_if #(.CNT_W(4), .LINE_W(3)) if3 ();

    assign if0.tick = tick; assign if0.hit = hit; assign if0.line_count = lc; assign if0.abort = abort;
    assign if1.tick = tick; assign if1.hit = hit; assign if1.line_count = lc; assign if1.abort = abort;
    assign if2.tick = tick; assign if2.hit = hit; assign if2.line_count = lc; assign if2.abort = abort;
    assign if3.tick = tick; assign if3.hit = hit; assign if3.line_count = lc; assign if3.abort = abort;

    line_clear_fx_timer #(.MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    line_clear_fx_timer #(.MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    line_clear_fx_timer #(.MODE(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    line_clear_fx_timer #(.CNT_W(4), .MODE(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, one entry per DUT.
    int m_mode[4] = '{0, 1, 2, 2};
    int m_cmax[4] = '{63, 63, 63, 15};
    int m_act[4], m_rem[4], m_lvl[4], m_fl[4], m_bc[4];

    logic [11:0] q0[$], q1[$], q2[$], q3[$];

    // Snapshot layout: {active, flash, level[2:0], remaining[5:0], done}
    function automatic logic [11:0] snap(int i);
        case (i)
            0:       return {if0.active, if0.flash, if0.level, if0.remaining, if0.done};
            1:       return {if1.active, if1.flash, if1.level, if1.remaining, if1.done};
            2:       return {if2.active, if2.flash, if2.level, if2.remaining, if2.done};
            default: return {if3.active, if3.flash, if3.level, 2'b00, if3.remaining, if3.done};
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0; m_rem[i] = 0; m_lvl[i] = 0; m_fl[i] = 0; m_bc[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit t, input bit h, input int l, input bit a,
                              output logic [11:0] e);
        int  d;
        bit  dn;
        dn = 1'b0;
        if (a) begin
            m_act[i] = 0; m_rem[i] = 0; m_lvl[i] = 0; m_fl[i] = 0; m_bc[i] = 0;
        end else if (h && l >= 1 && l <= 4) begin
            d = 3 + (l - 1) * 5;
            if (d > m_cmax[i]) d = m_cmax[i];
            if (m_act[i] == 0 || m_mode[i] == 0) begin
                m_act[i] = 1; m_rem[i] = d; m_lvl[i] = l; m_fl[i] = 1; m_bc[i] = 0;
            end else begin
                if (l > m_lvl[i]) m_lvl[i] = l;
                if (m_mode[i] == 1) m_rem[i] = (d > m_rem[i]) ? d : m_rem[i];
                else m_rem[i] = (m_rem[i] + d > m_cmax[i]) ? m_cmax[i] : m_rem[i] + d;
            end
        end else if (t && m_act[i] != 0) begin
            if (m_rem[i] == 1) begin
                m_act[i] = 0; m_rem[i] = 0; m_lvl[i] = 0; m_fl[i] = 0; m_bc[i] = 0;
                dn = 1'b1;
            end else begin
                m_rem[i]--;
                m_bc[i]++;
                if (m_bc[i] == 2) begin
                    m_bc[i] = 0;
                    m_fl[i] = 1 - m_fl[i];
                end
            end
        end
        e = {m_act[i][0], m_fl[i][0], 3'(m_lvl[i]), 6'(m_rem[i]), dn};
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the predicted result.
    task automatic cyc(input bit t, input bit h, input int l, input bit a);
        logic [11:0] e;
        @(negedge clk);
        tick = t; hit = h; lc = 3'(l); abort = a;
        for (int i = 0; i < 4; i++) begin
            model_step(i, t, h, l, a, e);
            case (i)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                2:       q2.push_back(e);
                default: q3.push_back(e);
            endcase
        end
    endtask

    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    task automatic monitor();
        logic [11:0] e;
        bit          have;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                have = 1'b0;
                case (i)
                    0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    2:       if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                    default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
                endcase
                if (have) begin
                    n_tests++;
                    if (snap(i) !== e) begin
                        n_fail++;
                        $display("FAIL sb dut%0d: got %h, expected %h at %0t", i, snap(i), e, $time);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; hit = 1'b0; lc = '0; abort = 1'b0;
        model_reset();
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("reset_dut%0d", i), int'(snap(i)), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 2-line effect with continuous ticks.
        cyc(0, 1, 2, 0);
        for (int k = 0; k < 10; k++) cyc(1, 0, 0, 0);

        // Invalid hits from idle, then inside a running countdown.
        for (int k = 0; k < 4; k++) cyc(1, 1, (k % 2) ? 5 : 0, 0);
        cyc(0, 1, 3, 0);
        for (int k = 0; k < 8; k++) cyc(1, 1, (k % 2) ? 7 : 0, 0);
        cyc(0, 0, 0, 1);

        // Retrigger policies: 4-line hit, 10 ticks, then a 1-line hit.
        cyc(0, 1, 4, 0);
        for (int k = 0; k < 10; k++) cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0);
        peek();
        chk("restart_rem", if0.remaining, 3);
        chk("restart_lvl", if0.level, 1);
        chk("restart_flash", if0.flash, 1);
        chk("extend_rem", if1.remaining, 8);
        chk("extend_lvl", if1.level, 4);
        chk("accum_rem", if2.remaining, 11);
        chk("accum_lvl", if2.level, 4);
        cyc(0, 0, 0, 1);

        // Saturation of the 4-bit accumulator, then a full 15-tick countdown.
        for (int k = 0; k < 3; k++) cyc(0, 1, 4, 0);
        peek();
        chk("sat_rem", if3.remaining, 15);
        for (int k = 0; k < 14; k++) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        peek();
        chk("sat_done", if3.done, 1);
        chk("sat_active", if3.active, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);

        // Abort coinciding with tick.
        cyc(0, 1, 2, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        peek();
        for (int i = 0; i < 4; i++) chk($sformatf("abort_dut%0d", i), int'(snap(i)), 0);

        // Tick held low mid-effect freezes the countdown.
        cyc(0, 1, 3, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0);
        peek();
        chk("freeze_rem", if0.remaining, 11);

        // Asynchronous reset between edges mid-countdown.
        cyc(1, 0, 0, 0);
        @(negedge clk);
        tick = 1'b0; hit = 1'b0; lc = '0; abort = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("async_rst_dut%0d", i), int'(snap(i)), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0, 0);
        peek();
        chk("post_rst_idle", if0.active, 0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            cyc(1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 15),
                int'($urandom_range(0, 7)),
                ($urandom_range(0, 99) < 2));
        end

        cyc(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        chk("sb_drained", q0.size() + q1.size() + q2.size() + q3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_clear_fx_timer.md
Name: line_clear_fx_timer

Overview:
- Parametrised line-clear effect timer for the score/display path. Successor to the single-channel hit-time stretcher.
- On a clear event, loads a duration derived from the number of lines cleared, then counts it down on a frame tick.
- Drives:
  - an "effect active" level,
  - a blink pattern for the flashing rows,
  - a latched effect level,
  - a one-cycle completion pulse for the scorer and renderer.
- Retrigger policy while an effect is running is selectable.

Parameters:
- CNT_W, 6, width of the remaining-ticks counter.
- LINE_W, 3, width of line_count.
- MAX_LINES, 4, largest valid line_count.
- BASE_TICKS, 3, duration for a 1-line clear.
- STEP_TICKS, 5, extra ticks per additional line.
- BLINK_TICKS, 2, ticks per flash half-period (≥1).
- MODE, 0, retrigger policy: 0 restart, 1 extend (max), 2 accumulate (saturating add).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  frame/time-base enable. Countdown advances only when tick=1.
- hit  in  1  clear event strobe, sampled each clk.
- line_count  in  LINE_W  lines cleared by this event, qualified by hit.
- abort  in  1  cancel any running effect (e.g. game reset).
- active  out  1  high while an effect runs.
- flash  out  1  blink pattern for the cleared rows. 0 when idle.
- level  out  LINE_W  line count of the current effect. 0 when idle.
- remaining  out  CNT_W  ticks left.
- done  out  1  one-cycle pulse when an effect expires naturally.

Behaviour:
- Reset (rst_n=0, async): state IDLE; active=0, flash=0, level=0, remaining=0, done=0, blink counter=0.
- All outputs are registered. Effects are visible the cycle after the sampling edge.
- Valid hit: hit=1 and 1 ≤ line_count ≤ MAX_LINES.
  - hit with line_count=0 or >MAX_LINES is ignored entirely. State and counters are unchanged.
- dur(n) = BASE_TICKS + (n-1)*STEP_TICKS, computed at CNT_W+LINE_W bits and saturated to 2^CNT_W-1.
- States: IDLE, RUN.
  - IDLE + valid hit → RUN:
    - remaining=dur(n), level=n, active=1, flash=1, blink counter=0.
  - RUN + valid hit, per MODE:
    - MODE 0: remaining=dur(n), level=n, flash=1, blink counter=0.
    - MODE 1: remaining=max(remaining,dur(n)), level=max(level,n). Flash phase continues.
    - MODE 2: remaining=sat(remaining+dur(n)), level=max(level,n). Flash phase continues.
  - RUN + tick (no valid hit, no abort):
    - remaining decrements by 1.
    - Blink counter increments. When it reaches BLINK_TICKS it returns to 0 and flash toggles.
  - RUN + tick with remaining=1:
    - Go to IDLE; remaining=0, active=0, flash=0, level=0.
    - done=1 for exactly one cycle.
  - RUN without tick: hold all values.
- Priority: abort > valid hit > tick.
  - abort: IDLE immediately with all outputs cleared and no done pulse, regardless of hit or tick.
  - Valid hit and tick in the same cycle: the hit is applied and no decrement occurs that cycle.
  - A hit on the same cycle as the final tick re-enters or stays in RUN with no done pulse.
- done is 0 in all cycles except natural expiry.
- remaining never underflows. In IDLE it is held at 0 and tick has no effect.
- Reset asserted mid-effect clears everything asynchronously. After release the block waits in IDLE for a new hit.

Test Plan (defaults unless stated; durations 3/8/13/18):
- Reset, then hit with line_count=2, then tick every cycle → active=1 and level=2 the next cycle, remaining 8→0 over 8 ticks. done pulses once as active falls. flash sequence 1,1,0,0,1,1,0,0 across ticks.
- hit with line_count=0 and hit with line_count=5 from IDLE, with ticks → no output ever changes. Same stimulus in RUN → countdown is undisturbed.
- MODE 0: line_count=4 hit, 10 ticks (remaining=8), then line_count=1 hit → remaining=3, level=1, flash restarts at 1. MODE 1 with the same stimulus → remaining=8, level=4. MODE 2 with the same stimulus → remaining=11, level=4.
- MODE 2 with CNT_W=4: three line_count=4 hits back-to-back → remaining saturates at 15. Countdown then takes 15 ticks, followed by a single done.
- Hit, 2 ticks, then abort and tick in the same cycle → next cycle all outputs are 0 and done stays 0. tick=0 held mid-effect → remaining frozen.
- Assert rst_n low asynchronously mid-countdown, between clock edges → outputs clear before the next edge. After release, a tick alone keeps the block IDLE.
